// File: rtl/rf_control_fsm.sv
// rf_control_fsm: multicycle execute/writeback controller for an 8x16 register file.
// Sequence per instruction: IDLE (accept) -> RD (file read latency) -> EX -> WB or MEM.
// Optional feature macro: CTRL_FLAGS_EN adds flag_z / flag_n result flags updated in WB.
module rf_control_fsm #(
  parameter int DW      = 16,
  parameter int SHAMT_W = 4
) (
  input  logic          CLK,
  input  logic          resetn,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [2:0]    regA,
  output logic [2:0]    regB,
  input  logic [DW-1:0] dataA,
  input  logic [DW-1:0] dataB,
  output logic          RFwrite,
  output logic [2:0]    regW,
  output logic [DW-1:0] dataW,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          illegal
`ifdef CTRL_FLAGS_EN
  ,
  output logic          flag_z,
  output logic          flag_n
`endif
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_MV  = 4'h5;
  localparam logic [3:0] OP_MVI = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   ir, ir_nxt;
  logic [3:0]    op;
  logic [2:0]    reg_a_nxt, reg_b_nxt, reg_w_nxt;
  logic          rf_write_nxt, illegal_nxt, mem_rd_nxt, mem_wr_nxt;
  logic [DW-1:0] data_w_nxt, mem_addr_nxt, mem_wdata_nxt;
`ifdef CTRL_FLAGS_EN
  logic          flag_z_nxt, flag_n_nxt;
`endif

  assign op          = ir[15:12];
  assign instr_ready = (state == S_IDLE);

  // Register-to-register ALU ops; results wrap modulo 2^DW.
  function automatic logic [DW-1:0] alu_result(
    input logic [3:0]    opc,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic [15:0]   ir_word
  );
    logic signed [DW-1:0] imm_ext;
    logic [SHAMT_W-1:0]   shamt;
    imm_ext = {{(DW-9){ir_word[8]}}, ir_word[8:0]};
    shamt   = ir_word[SHAMT_W-1:0];
    case (opc)
      OP_ADD:  alu_result = a + b;
      OP_SUB:  alu_result = a - b;
      OP_AND:  alu_result = a & b;
      OP_OR:   alu_result = a | b;
      OP_MV:   alu_result = b;
      OP_MVI:  alu_result = imm_ext;
      OP_SHL:  alu_result = a << shamt;
      OP_SHR:  alu_result = a >> shamt;
      default: alu_result = '0;
    endcase
  endfunction

  // State and registered outputs; reset returns to IDLE and clears every output.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      ir        <= '0;
      regA      <= '0;
      regB      <= '0;
      regW      <= '0;
      RFwrite   <= 1'b0;
      dataW     <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      illegal   <= 1'b0;
`ifdef CTRL_FLAGS_EN
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      ir        <= ir_nxt;
      regA      <= reg_a_nxt;
      regB      <= reg_b_nxt;
      regW      <= reg_w_nxt;
      RFwrite   <= rf_write_nxt;
      dataW     <= data_w_nxt;
      mem_rd    <= mem_rd_nxt;
      mem_wr    <= mem_wr_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      illegal   <= illegal_nxt;
`ifdef CTRL_FLAGS_EN
      flag_z    <= flag_z_nxt;
      flag_n    <= flag_n_nxt;
`endif
    end
  end

  // Next-state sequencing; MEM waits for the ack, then loads write back and stores finish.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (instr_valid) state_nxt = S_RD;
      S_RD:   state_nxt = S_EX;
      S_EX: begin
        if (op == OP_LD || op == OP_ST)        state_nxt = S_MEM;
        else if (op >= OP_ADD && op <= OP_SHR) state_nxt = S_WB;
        else                                   state_nxt = S_IDLE;
      end
      S_MEM:  if (mem_ack) state_nxt = (op == OP_LD) ? S_WB : S_IDLE;
      S_WB:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; RFwrite is set on entry to WB so it spans WB only.
  always_comb begin
    ir_nxt        = ir;
    reg_a_nxt     = regA;
    reg_b_nxt     = regB;
    reg_w_nxt     = regW;
    rf_write_nxt  = 1'b0;
    illegal_nxt   = 1'b0;
    data_w_nxt    = dataW;
    mem_rd_nxt    = mem_rd;
    mem_wr_nxt    = mem_wr;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
`ifdef CTRL_FLAGS_EN
    flag_z_nxt    = flag_z;
    flag_n_nxt    = flag_n;
`endif
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          ir_nxt    = instr;
          reg_a_nxt = instr[11:9];
          reg_b_nxt = instr[8:6];
        end
      end
      S_EX: begin
        if (op >= OP_ADD && op <= OP_SHR) begin
          data_w_nxt   = alu_result(op, dataA, dataB, ir);
          rf_write_nxt = 1'b1;
          reg_w_nxt    = ir[11:9];
        end else if (op == OP_LD || op == OP_ST) begin
          mem_rd_nxt    = (op == OP_LD);
          mem_wr_nxt    = (op == OP_ST);
          mem_addr_nxt  = dataB;
          mem_wdata_nxt = dataA;
        end else if (op != OP_NOP) begin
          illegal_nxt = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          mem_rd_nxt = 1'b0;
          mem_wr_nxt = 1'b0;
          if (op == OP_LD) begin
            data_w_nxt   = mem_rdata;
            rf_write_nxt = 1'b1;
            reg_w_nxt    = ir[11:9];
          end
        end
      end
      S_WB: begin
`ifdef CTRL_FLAGS_EN
        flag_z_nxt = (dataW == '0);
        flag_n_nxt = dataW[DW-1];
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_control_fsm.sv
// tb_rf_control_fsm: directed + random instruction stream against an 8x16 register file
// environment and a behavioural model of architectural register contents.
module tb_rf_control_fsm;

  logic        CLK = 1'b0;
  logic        resetn;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  regA, regB, regW;
  logic [15:0] dataA, dataB, dataW;
  logic        RFwrite, mem_rd, mem_wr, illegal, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CTRL_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] rf [8];
  int          ref_rf [8];
  int          exp_z = 0;
  int          exp_n = 0;

  rf_control_fsm #(.DW(16), .SHAMT_W(4)) dut (
    .CLK(CLK), .resetn(resetn), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .regA(regA), .regB(regB), .dataA(dataA), .dataB(dataB),
    .RFwrite(RFwrite), .regW(regW), .dataW(dataW), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .illegal(illegal)
`ifdef CTRL_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n)
`endif
  );

  always #5 CLK = ~CLK;

  // Register file environment: synchronous write, registered read.
  always @(posedge CLK) begin
    if (RFwrite) rf[regW] <= dataW;
    dataA <= rf[regA];
    dataB <= rf[regB];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags();
`ifdef CTRL_FLAGS_EN
    check("flag_z", {31'd0, flag_z}, exp_z);
    check("flag_n", {31'd0, flag_n}, exp_n);
`endif
  endtask

  // Issue one instruction and follow it through its fixed schedule, checking each step.
  task automatic run(input logic [3:0] op, input logic [2:0] rx, input logic [8:0] rest,
                     input int dly, input logic [15:0] rdata);
    logic [2:0] ry;
    longint     a, b, res, v;
    int         sh, cnt;
    bit         writes;
    ry = rest[8:6];
    a  = ref_rf[rx];
    b  = ref_rf[ry];
    sh = int'(rest[3:0]);
    writes = 1;
    res = 0;
    case (op)
      4'h1: res = (a + b) % 65536;
      4'h2: res = (a - b + 65536) % 65536;
      4'h3: res = a & b;
      4'h4: res = a | b;
      4'h5: res = b;
      4'h6: begin v = rest; if (v >= 256) v = v - 512; res = (v + 65536) % 65536; end
      4'h7: res = (a * (64'd1 << sh)) % 65536;
      4'h8: res = a / (64'd1 << sh);
      4'h9: res = rdata;
      default: writes = 0;
    endcase

    @(negedge CLK);
    check("ready_before_accept", {31'd0, instr_ready}, 1);
    instr = {op, rx, rest};
    instr_valid = 1'b1;
    @(negedge CLK);                       // RD
    instr_valid = 1'b0;
    instr = 16'($urandom);
    check("ready_low_rd", {31'd0, instr_ready}, 0);
    check("regA", {29'd0, regA}, rx);
    check("regB", {29'd0, regB}, ry);
    mem_ack = 1'b1;                       // stray ack outside MEM must be ignored
    mem_rdata = 16'($urandom);
    @(negedge CLK);                       // EX
    mem_ack = 1'b0;
    check("no_write_ex", {31'd0, RFwrite}, 0);
    @(negedge CLK);                       // result of EX
    if (op >= 4'h1 && op <= 4'h8) begin
      check("wb_rfwrite", {31'd0, RFwrite}, 1);
      check("wb_regW", {29'd0, regW}, rx);
      check("wb_dataW", {16'd0, dataW}, res);
      @(negedge CLK);
      check("rfwrite_one_cycle", {31'd0, RFwrite}, 0);
      check("ready_after_wb", {31'd0, instr_ready}, 1);
    end else if (op == 4'h9 || op == 4'hA) begin
      check("mem_rd_req", {31'd0, mem_rd}, (op == 4'h9));
      check("mem_wr_req", {31'd0, mem_wr}, (op == 4'hA));
      check("mem_addr", {16'd0, mem_addr}, b);
      check("mem_wdata", {16'd0, mem_wdata}, a);
      cnt = 0;
      for (int k = 1; k <= dly; k++) begin
        if (k > 1) @(negedge CLK);
        if ((mem_rd | mem_wr) && mem_addr == 16'(b)) cnt++;
        if (k == dly) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end
      @(negedge CLK);
      mem_ack = 1'b0;
      check("mem_req_cycles", cnt, dly);
      check("mem_req_dropped", {30'd0, mem_rd, mem_wr}, 0);
      if (op == 4'h9) begin
        check("ld_rfwrite", {31'd0, RFwrite}, 1);
        check("ld_regW", {29'd0, regW}, rx);
        check("ld_dataW", {16'd0, dataW}, res);
        @(negedge CLK);
      end else begin
        check("st_no_write", {31'd0, RFwrite}, 0);
      end
      check("ready_after_mem", {31'd0, instr_ready}, 1);
    end else if (op == 4'h0) begin
      check("nop_no_write", {31'd0, RFwrite}, 0);
      check("nop_ready", {31'd0, instr_ready}, 1);
    end else begin
      check("illegal_pulse", {31'd0, illegal}, 1);
      check("illegal_no_write", {31'd0, RFwrite}, 0);
      check("illegal_no_mem", {30'd0, mem_rd, mem_wr}, 0);
      check("illegal_ready", {31'd0, instr_ready}, 1);
      @(negedge CLK);
      check("illegal_once", {31'd0, illegal}, 0);
    end
    if (writes) begin
      ref_rf[rx] = int'(res);
      exp_z = (res == 0) ? 1 : 0;
      exp_n = (res >= 32768) ? 1 : 0;
    end
    check_flags();
  endtask

  initial begin
    int hits;
    logic [3:0] rop;
    resetn = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 0;
    #12;
    check("rst_ready", {31'd0, instr_ready}, 1);
    check("rst_outs1", {26'd0, RFwrite, mem_rd, mem_wr, illegal, regW}, 0);
    check("rst_regs", {26'd0, regA, regB}, 0);
    check("rst_dataW", {16'd0, dataW}, 0);
    check("rst_mem", {mem_addr, mem_wdata}, 0);
    check_flags();
    @(negedge CLK);
    resetn = 1'b1;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (RFwrite || !instr_ready) hits++;
    end
    check("idle_quiet", hits, 0);

    // Initialise every register through MVI.
    for (int i = 0; i < 8; i++) run(4'h6, 3'(i), 9'($urandom), 1, 16'h0);

    run(4'h6, 3'd1, 9'd5, 1, 16'h0);
    run(4'h6, 3'd2, 9'd7, 1, 16'h0);
    run(4'h1, 3'd1, {3'd2, 6'd0}, 1, 16'h0);           // ADD r1,r2 -> 12
    run(4'h6, 3'd6, 9'd0, 1, 16'h0);
    run(4'h6, 3'd7, 9'd1, 1, 16'h0);
    run(4'h2, 3'd6, {3'd7, 6'd0}, 1, 16'h0);           // SUB 0-1 -> FFFF
    run(4'h6, 3'd4, 9'h1FD, 1, 16'h0);                 // MVI -3 -> FFFD
    run(4'h6, 3'd1, 9'd3, 1, 16'h0);
    run(4'h7, 3'd1, {3'd0, 2'd0, 4'hF}, 1, 16'h0);     // SHL 3 by 15 -> 8000
    run(4'h8, 3'd1, {3'd0, 2'd0, 4'h3}, 1, 16'h0);     // SHR 8000 by 3 -> 1000
    run(4'h9, 3'd2, {3'd5, 6'd0}, 4, 16'hBEEF);        // LD r2,[r5], ack after 4
    run(4'h5, 3'd0, {3'd2, 6'd0}, 1, 16'h0);           // MV r0,r2 sees BEEF
    run(4'hA, 3'd2, {3'd5, 6'd0}, 2, 16'h0);           // ST r2,[r5]
    run(4'hF, 3'd3, 9'd0, 1, 16'h0);                   // illegal
    run(4'h2, 3'd3, {3'd3, 6'd0}, 1, 16'h0);           // SUB r3,r3 -> 0
    run(4'h0, 3'd3, 9'd0, 1, 16'h0);                   // NOP

    // Reset while a load waits in MEM.
    @(negedge CLK);
    instr = {4'h9, 3'd1, 3'd2, 6'd0};
    instr_valid = 1'b1;
    @(negedge CLK);
    instr_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("mid_ld_pending", {31'd0, mem_rd}, 1);
    #2 resetn = 1'b0;
    #1;
    check("async_mem_rd_drop", {31'd0, mem_rd}, 0);
    check("async_idle", {31'd0, instr_ready}, 1);
    check("async_no_write", {31'd0, RFwrite}, 0);
    exp_z = 0;
    exp_n = 0;
    check_flags();
    @(negedge CLK);
    resetn = 1'b1;

    // Random instruction stream.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      run(rop, 3'($urandom), 9'($urandom), int'($urandom_range(1, 3)), 16'($urandom));
    end
    // Register file contents must match the architectural model.
    @(negedge CLK);
    for (int i = 0; i < 8; i++) check("rf_final", {16'd0, rf[i]}, ref_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
